// File: rtl/multiplier_seq_bcd.sv
// multiplier_seq_bcd
// Sequential shift-add multiplier. Both operands enter over one shared data bus.
// The product magnitude is converted to packed BCD by a sequential
// double-dabble engine.
//
// Ports
//   i_clk, i_rst      clock (rising edge); asynchronous active-high reset
//   i_clear           synchronous soft clear of the operands and the FSM
//   i_load            load strobe; only a rising edge captures i_data
//   i_start           level-sampled start request, accepted in HAVE_AB
//   i_signed          1 = two's-complement operands, sampled with start
//   i_data[W-1:0]     operand value
//   o_ready           both operands are held and a start is accepted
//   o_busy            PREP/MUL/BCD in progress
//   o_done            one-cycle pulse when o_P/o_neg/o_bcd update
//   o_A, o_B          raw operand registers
//   o_P[2W-1:0]       product, in two's complement when signed
//   o_neg             product is negative (never set for a zero product)
//   o_bcd[4D-1:0]     BCD magnitude; digit 0 is in bits [3:0]
//
// Handshake: o_ready is high only in HAVE_AB. i_start is taken in any HAVE_AB
// cycle that has no load edge. After the start, o_busy stays high for
// 3*WIDTH+1 cycles. Then o_done pulses for exactly one cycle. If i_start is
// still high, another run starts.
//
// The internal signal `state` is the FSM debug hook.
module multiplier_seq_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic                  i_start,
    input  logic                  i_signed,
    input  logic [WIDTH-1:0]      i_data,
    output logic                  o_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [WIDTH-1:0]      o_A,
    output logic [WIDTH-1:0]      o_B,
    output logic [2*WIDTH-1:0]    o_P,
    output logic                  o_neg,
    output logic [4*DIGITS-1:0]   o_bcd
);

    localparam int CW = $clog2(2*WIDTH) + 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] BCD_LAST = CW'(2*WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, HAVE_A, HAVE_AB, PREP, MUL, BCD, DONE
    } state_t;

    state_t                state;
    logic                  load_prev;
    logic                  toggle;      // 0: next reload goes to A, 1: to B
    logic                  mode_signed;
    logic                  sign;
    logic [WIDTH-1:0]      a_reg, b_reg;
    logic [2*WIDTH-1:0]    mcand;
    logic [WIDTH-1:0]      mplier;
    logic [2*WIDTH-1:0]    acc;
    logic [2*WIDTH-1:0]    bin_work;
    logic [4*DIGITS-1:0]   bcd_work;
    logic [CW-1:0]         cnt;

    logic                  load_edge;
    logic [WIDTH-1:0]      mag_a, mag_b;
    logic [2*WIDTH-1:0]    acc_next;
    logic [4*DIGITS-1:0]   bcd_adj, bcd_next;

    // Before each shift, add 3 to every digit that is 5 or more.
    function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        load_edge = i_load & ~load_prev;
        // The most negative value negates to itself, which is still the
        // correct unsigned magnitude.
        mag_a     = (mode_signed && a_reg[WIDTH-1]) ? (~a_reg + 1'b1) : a_reg;
        mag_b     = (mode_signed && b_reg[WIDTH-1]) ? (~b_reg + 1'b1) : b_reg;
        acc_next  = mplier[0] ? (acc + mcand) : acc;
        bcd_adj   = add3(bcd_work);
        bcd_next  = (bcd_adj << 1) | {{(4*DIGITS-1){1'b0}}, bin_work[2*WIDTH-1]};
    end

    assign o_ready = (state == HAVE_AB);
    assign o_busy  = (state == PREP) || (state == MUL) || (state == BCD);
    assign o_A     = a_reg;
    assign o_B     = b_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            load_prev   <= 1'b1;   // a load held high through reset is not an edge
            toggle      <= 1'b0;
            mode_signed <= 1'b0;
            sign        <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            bin_work    <= '0;
            bcd_work    <= '0;
            cnt         <= '0;
            o_done      <= 1'b0;
            o_P         <= '0;
            o_neg       <= 1'b0;
            o_bcd       <= '0;
        end else begin
            load_prev <= i_load;
            o_done    <= 1'b0;
            if (i_clear) begin
                // o_P, o_neg and o_bcd keep the last result.
                state    <= IDLE;
                toggle   <= 1'b0;
                sign     <= 1'b0;
                a_reg    <= '0;
                b_reg    <= '0;
                mcand    <= '0;
                mplier   <= '0;
                acc      <= '0;
                bin_work <= '0;
                bcd_work <= '0;
                cnt      <= '0;
            end else begin
                unique case (state)
                    IDLE: if (load_edge) begin
                        a_reg <= i_data;
                        state <= HAVE_A;
                    end
                    HAVE_A: if (load_edge) begin
                        b_reg  <= i_data;
                        toggle <= 1'b0;
                        state  <= HAVE_AB;
                    end
                    HAVE_AB: begin
                        // A load edge takes priority over start in the same cycle.
                        if (load_edge) begin
                            if (toggle) b_reg <= i_data;
                            else        a_reg <= i_data;
                            toggle <= ~toggle;
                        end else if (i_start) begin
                            mode_signed <= i_signed;
                            state       <= PREP;
                        end
                    end
                    PREP: begin
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        acc    <= '0;
                        sign   <= mode_signed & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                        cnt    <= '0;
                        state  <= MUL;
                    end
                    MUL: begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (cnt == MUL_LAST) begin
                            bin_work <= acc_next;
                            bcd_work <= '0;
                            cnt      <= '0;
                            state    <= BCD;
                        end
                    end
                    BCD: begin
                        bcd_work <= bcd_next;
                        bin_work <= bin_work << 1;
                        cnt      <= cnt + 1'b1;
                        if (cnt == BCD_LAST) begin
                            o_P    <= sign ? (~acc + 1'b1) : acc;
                            o_neg  <= sign & (acc != '0);
                            o_bcd  <= bcd_next;
                            o_done <= 1'b1;
                            state  <= DONE;
                        end
                    end
                    DONE:    state <= HAVE_AB;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multiplier_seq_bcd.sv
module tb_multiplier_seq_bcd;
    localparam int W = 8;
    localparam int D = 5;
    localparam int EW = 2*W + 2*W + 1 + 4*D;   // {a, b, p, neg, bcd}

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic           i_clear = 1'b0, i_load = 1'b0, i_start = 1'b0, i_signed = 1'b0;
    logic [W-1:0]   i_data = '0;
    logic           o_ready, o_busy, o_done, o_neg;
    logic [W-1:0]   o_A, o_B;
    logic [2*W-1:0] o_P;
    logic [4*D-1:0] o_bcd;

    logic [EW-1:0]  exp_q[$];
    int             n_checks = 0;
    int             n_pass = 0;
    int             done_cnt = 0;

    multiplier_seq_bcd #(.WIDTH(W), .DIGITS(D)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear), .i_load(i_load),
        .i_start(i_start), .i_signed(i_signed), .i_data(i_data),
        .o_ready(o_ready), .o_busy(o_busy), .o_done(o_done), .o_A(o_A), .o_B(o_B),
        .o_P(o_P), .o_neg(o_neg), .o_bcd(o_bcd)
    );

    // ---- clock / reset ----
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // ---- scoreboard monitor ----
    always @(negedge i_clk) begin
        if (!i_rst && o_done === 1'b1) begin
            logic [EW-1:0] e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(o_done), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("res_A",   64'(o_A),   64'(e[EW-1 -: W]));
                check("res_B",   64'(o_B),   64'(e[EW-W-1 -: W]));
                check("res_P",   64'(o_P),   64'(e[4*D+2*W : 4*D+1]));
                check("res_neg", 64'(o_neg), 64'(e[4*D]));
                check("res_bcd", 64'(o_bcd), 64'(e[4*D-1:0]));
            end
        end
    end

    // ---- driver tasks ----
    task automatic load(input logic [W-1:0] v);
        @(negedge i_clk); i_data = v; i_load = 1'b1;
        @(negedge i_clk); i_load = 1'b0;
    endtask

    task automatic clear();
        @(negedge i_clk); i_clear = 1'b1;
        @(negedge i_clk); i_clear = 1'b0;
    endtask

    // Issue a start, push the expected result, and time the busy/done window.
    task automatic run(input logic sgn, input logic [W-1:0] ea, input logic [W-1:0] eb,
                       input logic [2*W-1:0] ep, input logic en, input logic [4*D-1:0] ebcd);
        int j;
        int busy_n;
        bit seen;
        exp_q.push_back({ea, eb, ep, en, ebcd});
        @(negedge i_clk); i_signed = sgn; i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;   // first negedge after start edge t0
        busy_n = 0;
        seen = 1'b0;
        j = 0;
        while (j < 60 && !seen) begin
            if (o_done === 1'b1) seen = 1'b1;
            else begin
                if (o_busy === 1'b1) busy_n++;
                j++;
                @(negedge i_clk);
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        check("done_latency", 64'(j), 64'(3*W + 1));
        check("busy_cycles", 64'(busy_n), 64'(3*W + 1));
        @(negedge i_clk);
        check("done_pulse_1cyc", 64'(o_done), 64'd0);
        check("ready_after", 64'(o_ready), 64'd1);
    endtask

    // ---- stimulus ----
    initial begin
        int d0;
        repeat (2) @(negedge i_clk);
        check("rst_ready", 64'(o_ready), 64'd0);
        check("rst_busy",  64'(o_busy),  64'd0);
        check("rst_done",  64'(o_done),  64'd0);
        check("rst_A",     64'(o_A),     64'd0);
        check("rst_B",     64'(o_B),     64'd0);
        check("rst_P",     64'(o_P),     64'd0);
        check("rst_neg",   64'(o_neg),   64'd0);
        check("rst_bcd",   64'(o_bcd),   64'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Unsigned 255 x 255
        load(8'd255); load(8'd255);
        check("ready_ab", 64'(o_ready), 64'd1);
        run(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 20'h65025);

        // Signed -128 x 127
        clear();
        load(8'h80); load(8'h7F);
        run(1'b1, 8'h80, 8'h7F, 16'hC080, 1'b1, 20'h16256);

        // Reload alternation: third load replaces A, fourth replaces B
        clear();
        load(8'd12); load(8'd34); load(8'd56);
        check("alt_A", 64'(o_A), 64'd56);
        check("alt_B", 64'(o_B), 64'd34);
        run(1'b0, 8'd56, 8'd34, 16'd1904, 1'b0, 20'h01904);
        load(8'd7);
        run(1'b0, 8'd56, 8'd7, 16'd392, 1'b0, 20'h00392);

        // Clear in MUL cycle 3: no done, last result kept
        clear();
        load(8'd3); load(8'd4);
        d0 = done_cnt;
        @(negedge i_clk); i_signed = 1'b0; i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;              // PREP
        repeat (3) @(negedge i_clk);                   // MUL cycle 3
        i_clear = 1'b1;
        @(negedge i_clk); i_clear = 1'b0;
        check("abort_busy",  64'(o_busy),  64'd0);
        check("abort_ready", 64'(o_ready), 64'd0);
        check("abort_A",     64'(o_A),     64'd0);
        check("abort_P",     64'(o_P),     64'd392);
        check("abort_bcd",   64'(o_bcd),   64'h00392);
        repeat (30) @(negedge i_clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);

        // Zero product in signed mode gives no sign; repeat start without reload
        load(8'd0); load(8'hFB);
        run(1'b1, 8'd0, 8'hFB, 16'd0, 1'b0, 20'h0);
        run(1'b1, 8'd0, 8'hFB, 16'd0, 1'b0, 20'h0);

        // A load edge wins over a start in the same cycle
        clear();
        load(8'd9); load(8'd10);
        @(negedge i_clk); i_data = 8'd11; i_load = 1'b1; i_start = 1'b1;
        @(negedge i_clk); i_load = 1'b0; i_start = 1'b0;
        check("same_cyc_busy", 64'(o_busy), 64'd0);
        check("same_cyc_A",    64'(o_A),    64'd11);
        run(1'b0, 8'd11, 8'd10, 16'd110, 1'b0, 20'h00110);

        // Reset during BCD, with load held high across the reset release
        @(negedge i_clk); i_signed = 1'b0; i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
        repeat (12) @(negedge i_clk);
        check("pre_rst_busy", 64'(o_busy), 64'd1);
        i_data = 8'h55; i_load = 1'b1;
        #1 i_rst = 1'b1;
        #1;
        check("arst_busy", 64'(o_busy), 64'd0);
        check("arst_P",    64'(o_P),    64'd0);
        check("arst_bcd",  64'(o_bcd),  64'd0);
        check("arst_A",    64'(o_A),    64'd0);
        @(negedge i_clk); i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        check("held_load_A",     64'(o_A),     64'd0);
        check("held_load_ready", 64'(o_ready), 64'd0);
        i_load = 1'b0;
        load(8'h5A);
        check("fresh_edge_A", 64'(o_A), 64'h5A);

        repeat (3) @(negedge i_clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
